// File: rtl/serv_trace_pkg.sv
// Shared constants for the retirement-trace packer: packet sizes, header bits, record layout.
// SERV_TRACE_TIMESTAMP_EN adds a 16-bit enqueue timestamp to every record and packet.
package serv_trace_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    localparam int PKT_LEN_BASE = 14;
    localparam int PKT_LEN_TS   = 16;

    localparam int HDR_TRAP_BIT = 7;
    localparam int HDR_OVF_BIT  = 6;
    localparam int HDR_RD_LSB   = 0;

    // Record layout, LSB upward; rd_wdata is already zeroed for rd_addr==0
    localparam int REC_WDATA_LSB = 0;
    localparam int REC_INSN_LSB  = 32;
    localparam int REC_PC_LSB    = 64;
    localparam int REC_RD_LSB    = 96;
    localparam int REC_OVF_BIT   = 101;
    localparam int REC_TRAP_BIT  = 102;
    localparam int REC_TS_LSB    = 103;
    localparam int REC_W_BASE    = 103;
    localparam int REC_W_TS      = REC_W_BASE + 16;

`ifdef SERV_TRACE_TIMESTAMP_EN
    localparam int PKT_LEN = PKT_LEN_TS;
    localparam int REC_W   = REC_W_TS;
`else
    localparam int PKT_LEN = PKT_LEN_BASE;
    localparam int REC_W   = REC_W_BASE;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_BODY = 2'd2
    } state_t;

endpackage

// File: rtl/serv_trace_fifo.sv
// Generic synchronous FIFO; push when full and pop when empty are ignored.
module serv_trace_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign o_full  = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign o_empty = (count == '0);
    assign o_count = count;
    assign o_rdata = mem[rd_ptr];

    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_wdata;
        end
    end

    // Pointers are exactly DEPTH_LOG2 wide so they wrap modulo depth
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serv_trace_packer.sv
// Buffers retirement records and serialises each as a SYNC-led byte packet on a valid/ready stream.
// SERV_TRACE_TIMESTAMP_EN: adds a free-running 16-bit cycle stamp sent after the header.
//
//  state | meaning
//  IDLE  | no packet in flight, waiting for a buffered record
//  SYNC  | presenting the SYNC byte of the head record's packet
//  BODY  | presenting body byte idx (header, [timestamp], pc, insn, rd_wdata)
module serv_trace_packer
    import serv_trace_pkg::*;
#(
    parameter int         DEPTH_LOG2 = 2,
    parameter logic [7:0] SYNC       = SYNC_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_insn,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_rd_wdata,
    input  logic        i_trap,
    output logic [7:0]  o_tdata,
    output logic        o_tvalid,
    input  logic        i_tready,
    output logic [7:0]  o_drop_cnt,
    output logic        o_busy
);

    localparam int         BODY_BYTES = PKT_LEN - 1;
    localparam logic [3:0] LAST_IDX   = 4'(PKT_LEN - 2);

    logic [REC_W-1:0]        rec_in;
    logic [REC_W-1:0]        rec_head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DEPTH_LOG2:0]     fifo_count;
    logic                    push;
    logic                    drop;
    logic                    pop;
    logic                    hs;
    logic                    ovf_q;
    logic [7:0]              drop_cnt_q;
    state_t                  state_q;
    state_t                  state_d;
    logic [3:0]              idx_q;
    logic [3:0]              idx_d;
    logic [7:0]              header;
    logic [8*BODY_BYTES-1:0] body;

    // Fullness is the registered count, so a same-cycle pop never rescues a record
    assign push = i_valid & ~fifo_full;
    assign drop = i_valid & fifo_full;
    assign hs   = o_tvalid & i_tready;
    assign pop  = hs & (state_q == ST_BODY) & (idx_q == LAST_IDX);

`ifdef SERV_TRACE_TIMESTAMP_EN
    logic [15:0] ts_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) ts_q <= '0;
        else       ts_q <= ts_q + 16'd1;
    end
`endif

    always_comb begin
        rec_in = '0;
        rec_in[REC_WDATA_LSB +: 32] = (i_rd_addr == 5'd0) ? 32'd0 : i_rd_wdata;
        rec_in[REC_INSN_LSB +: 32]  = i_insn;
        rec_in[REC_PC_LSB +: 32]    = i_pc;
        rec_in[REC_RD_LSB +: 5]     = i_rd_addr;
        rec_in[REC_OVF_BIT]         = ovf_q;
        rec_in[REC_TRAP_BIT]        = i_trap;
`ifdef SERV_TRACE_TIMESTAMP_EN
        rec_in[REC_TS_LSB +: 16]    = ts_q;
`endif
    end

    serv_trace_fifo #(
        .WIDTH      (REC_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_wdata (rec_in),
        .i_pop   (pop),
        .o_rdata (rec_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (push) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign o_drop_cnt = drop_cnt_q;

    always_comb begin
        header                = '0;
        header[HDR_TRAP_BIT]  = rec_head[REC_TRAP_BIT];
        header[HDR_OVF_BIT]   = rec_head[REC_OVF_BIT];
        header[HDR_RD_LSB +: 5] = rec_head[REC_RD_LSB +: 5];
    end

    assign body = {rec_head[REC_WDATA_LSB +: 32],
                   rec_head[REC_INSN_LSB +: 32],
                   rec_head[REC_PC_LSB +: 32],
`ifdef SERV_TRACE_TIMESTAMP_EN
                   rec_head[REC_TS_LSB +: 16],
`endif
                   header};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Count is sampled before the pop, so count>1 means another packet follows with no gap
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (i_tready) state_d = ST_BODY;
            end
            ST_BODY: begin
                if (i_tready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (fifo_count > (DEPTH_LOG2+1)'(1)) ? ST_SYNC : ST_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        o_tvalid = 1'b0;
        o_tdata  = 8'h00;
        case (state_q)
            ST_SYNC: begin
                o_tvalid = 1'b1;
                o_tdata  = SYNC;
            end
            ST_BODY: begin
                o_tvalid = 1'b1;
                o_tdata  = body[{idx_q, 3'b000} +: 8];
            end
            default: begin
                o_tvalid = 1'b0;
                o_tdata  = 8'h00;
            end
        endcase
    end

    assign o_busy = (state_q != ST_IDLE) | (fifo_count != '0);

endmodule
